// File: rtl/grant_mux_pkg.sv
// Shared types and constants for the grant_mux slice.
package grant_mux_pkg;
  localparam int NUM_PORTS  = 4;
  localparam int BEAT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } gm_state_t;
endpackage

// File: rtl/grant_mux_if.sv
// Bundle of grant, master data channels and the shared output bus around grant_mux.
// The timeout pulse exists only when GRANT_MUX_TIMEOUT_EN is defined.
interface grant_mux_if
  import grant_mux_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic              ack0, ack1, ack2, ack3;
  logic [DATA_W-1:0] data0, data1, data2, data3;
  logic              vld0, vld1, vld2, vld3;
  logic              rdy0, rdy1, rdy2, rdy3;
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              out_rdy;
  logic              done;
  logic              busy;
  logic              err_grant;
`ifdef GRANT_MUX_TIMEOUT_EN
  logic              timeout;

  modport master (
    output ack0, ack1, ack2, ack3, data0, data1, data2, data3,
    output vld0, vld1, vld2, vld3, out_rdy,
    input  rdy0, rdy1, rdy2, rdy3, out_data, out_vld, done, busy, err_grant, timeout
  );

  modport slave (
    input  ack0, ack1, ack2, ack3, data0, data1, data2, data3,
    input  vld0, vld1, vld2, vld3, out_rdy,
    output rdy0, rdy1, rdy2, rdy3, out_data, out_vld, done, busy, err_grant, timeout
  );
`else
  modport master (
    output ack0, ack1, ack2, ack3, data0, data1, data2, data3,
    output vld0, vld1, vld2, vld3, out_rdy,
    input  rdy0, rdy1, rdy2, rdy3, out_data, out_vld, done, busy, err_grant
  );

  modport slave (
    input  ack0, ack1, ack2, ack3, data0, data1, data2, data3,
    input  vld0, vld1, vld2, vld3, out_rdy,
    output rdy0, rdy1, rdy2, rdy3, out_data, out_vld, done, busy, err_grant
  );
`endif
endinterface

// File: rtl/grant_mux_onehot_enc4.sv
// Grant decoder: index of the lowest set grant bit plus a flag for more than one bit set.
module onehot_enc4
  import grant_mux_pkg::*;
(
  input  logic [NUM_PORTS-1:0] grant_i,
  output logic [1:0]           idx_o,
  output logic                 multi_o
);

  always_comb begin
    idx_o = 2'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (grant_i[i]) idx_o = 2'(i);
    end
    multi_o = (grant_i & (grant_i - NUM_PORTS'(1))) != '0;
  end

endmodule

// File: rtl/grant_mux.sv
// Latches the arbiter's grant, moves a BURST_LEN-beat burst onto the shared registered bus, pulses done.
// Optional watchdog abort enabled by defining GRANT_MUX_TIMEOUT_EN.
module grant_mux
  import grant_mux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TO_CYCLES = 16
) (
  input logic       clk,
  input logic       rst,
  grant_mux_if.slave bus
);

  localparam logic [BEAT_CNT_W-1:0] LastCnt = BEAT_CNT_W'(BURST_LEN - 1);

  logic [NUM_PORTS-1:0] ackVec, vldVec, rdyVec;
  logic [DATA_W-1:0]    dataArr [NUM_PORTS];

  gm_state_t            state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [BEAT_CNT_W-1:0] beatCnt_q, beatCnt_d;
  logic [DATA_W-1:0]    outData_q;
  logic                 outVld_q;

  logic [1:0] encIdx;
  logic       encMulti;
  logic       accept, doneNow, errGrant, wdExpire;

  assign ackVec     = {bus.ack3, bus.ack2, bus.ack1, bus.ack0};
  assign vldVec     = {bus.vld3, bus.vld2, bus.vld1, bus.vld0};
  assign dataArr[0] = bus.data0;
  assign dataArr[1] = bus.data1;
  assign dataArr[2] = bus.data2;
  assign dataArr[3] = bus.data3;

  onehot_enc4 u_enc (
    .grant_i (ackVec),
    .idx_o   (encIdx),
    .multi_o (encMulti)
  );

  // A beat moves only when the output register is empty or being emptied this cycle.
  assign accept = (state_q == XFER) && vldVec[sel_q] && (!outVld_q || bus.out_rdy);

`ifdef GRANT_MUX_TIMEOUT_EN
  localparam int WdW = $clog2(TO_CYCLES + 1);
  logic [WdW-1:0] wdCnt_q, wdCnt_d;

  assign wdExpire = (state_q == XFER) && !accept && (wdCnt_q == WdW'(TO_CYCLES - 1));
  assign wdCnt_d  = (state_q != XFER || accept) ? '0 : wdCnt_q + WdW'(1);

  always_ff @(posedge clk) begin
    if (!rst) wdCnt_q <= '0;
    else      wdCnt_q <= wdCnt_d;
  end

  assign bus.timeout = wdExpire;
`else
  // Without the watchdog this is constant low for any legal limit.
  assign wdExpire = (TO_CYCLES < 0);
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    beatCnt_d = beatCnt_q;
    rdyVec    = '0;
    doneNow   = 1'b0;
    errGrant  = 1'b0;
    case (state_q)
      IDLE: begin
        if (encMulti) begin
          errGrant = 1'b1;
        end else if (|ackVec) begin
          sel_d     = encIdx;
          beatCnt_d = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          rdyVec[sel_q] = 1'b1;
          beatCnt_d     = beatCnt_q + BEAT_CNT_W'(1);
          if (beatCnt_q == LastCnt) state_d = DRAIN;
        end else if (wdExpire) begin
          doneNow = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!outVld_q || bus.out_rdy) begin
          doneNow = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The output register drains independently of the FSM so an aborted burst still empties.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      beatCnt_q <= '0;
      outData_q <= '0;
      outVld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      beatCnt_q <= beatCnt_d;
      if (accept) begin
        outData_q <= dataArr[sel_q];
        outVld_q  <= 1'b1;
      end else if (bus.out_rdy) begin
        outVld_q  <= 1'b0;
      end
    end
  end

  assign bus.rdy0      = rdyVec[0];
  assign bus.rdy1      = rdyVec[1];
  assign bus.rdy2      = rdyVec[2];
  assign bus.rdy3      = rdyVec[3];
  assign bus.out_data  = outData_q;
  assign bus.out_vld   = outVld_q;
  assign bus.done      = doneNow;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err_grant = errGrant;

endmodule

// File: tb/tb_grant_mux.sv
// Self-checking bench for grant_mux: directed scenarios plus randomized bursts against a beat-stream model.
// The timeout scenario is compiled only when GRANT_MUX_TIMEOUT_EN is defined.
module tb_grant_mux;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  grant_mux_if #(.DATA_W(DW)) bus ();

  grant_mux #(
    .DATA_W    (DW),
    .BURST_LEN (BL),
    .TO_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Observations collected by applyStimulus for one burst
  logic [DW-1:0] outQ [$];
  int rdyCount, doneCount, wrongRdy, holdBad;
  int doneCycle, lastPushCycle, firstPushCycle, firstRdyCycle;

  task automatic drivePort(input int p, input logic a, input logic v, input logic [DW-1:0] d);
    case (p)
      0: begin bus.ack0 = a; bus.vld0 = v; bus.data0 = d; end
      1: begin bus.ack1 = a; bus.vld1 = v; bus.data1 = d; end
      2: begin bus.ack2 = a; bus.vld2 = v; bus.data2 = d; end
      default: begin bus.ack3 = a; bus.vld3 = v; bus.data3 = d; end
    endcase
  endtask

  function automatic logic [3:0] rdyBits();
    return {bus.rdy3, bus.rdy2, bus.rdy1, bus.rdy0};
  endfunction

  task automatic idleInputs();
    for (int q = 0; q < 4; q++) drivePort(q, 1'b0, 1'b0, DW'($urandom));
    bus.out_rdy = 1'b1;
  endtask

  // Reference: a burst from base must come out as base, base+1, ... each exactly once.
  function automatic bit streamMatches(input logic [DW-1:0] base);
    if (outQ.size() != BL) return 1'b0;
    for (int k = 0; k < BL; k++) begin
      if (outQ[k] !== base + DW'(k)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Acts as the granted master: offers base+idx and advances only on its own vld&rdy handshake.
  task automatic applyStimulus(input int p, input logic [DW-1:0] base, input int vldPct,
                               input int rdyPct, input int dropAfter, input int holdCycles);
    int idx, stall, hold, cyc;
    logic vNow, rNow, holdNow;
    logic [3:0] rb;
    idx = 0; stall = 0; hold = 0; cyc = 0;
    outQ.delete();
    rdyCount = 0; doneCount = 0; wrongRdy = 0; holdBad = 0;
    doneCycle = -1; lastPushCycle = -1; firstPushCycle = -1; firstRdyCycle = -1;
    @(negedge clk);
    idleInputs();
    drivePort(p, 1'b1, 1'b0, base);
    for (int b = 0; b < 300; b++) begin
      @(negedge clk);
      cyc++;
      holdNow = (hold > 0);
      vNow = (idx < BL) && ((int'($urandom_range(99)) < vldPct) || stall >= 6);
      rNow = !holdNow && ((int'($urandom_range(99)) < rdyPct) || stall >= 6);
      for (int q = 0; q < 4; q++) begin
        if (q != p) drivePort(q, 1'b0, 1'($urandom), DW'($urandom));
      end
      drivePort(p, !(dropAfter >= 0 && idx >= dropAfter), vNow, base + DW'(idx));
      bus.out_rdy = rNow;
      if (hold > 0) hold--;
      #1;
      rb = rdyBits();
      for (int q = 0; q < 4; q++) begin
        if (q != p && rb[q]) wrongRdy++;
      end
      if (holdNow && (bus.out_data !== base || rb[p])) holdBad++;
      if (bus.out_vld && bus.out_rdy) begin
        outQ.push_back(bus.out_data);
        lastPushCycle = cyc;
        if (firstPushCycle < 0) firstPushCycle = cyc;
      end
      if (rb[p] && vNow) begin
        rdyCount++;
        if (firstRdyCycle < 0) firstRdyCycle = cyc;
        idx++;
        stall = 0;
        if (idx == 1 && holdCycles > 0) hold = holdCycles;
      end else begin
        stall++;
      end
      if (bus.done) begin
        doneCount++;
        doneCycle = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkCount++;
    if (bus.out_vld !== 1'b0) $display("[TB] FAIL reset_out_vld: got %0b expected 0", bus.out_vld);
    else passCount++;
    checkCount++;
    if (bus.out_data !== '0) $display("[TB] FAIL reset_out_data: got 0x%0h expected 0x0", bus.out_data);
    else passCount++;
    checkCount++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_grant !== 1'b0)
      $display("[TB] FAIL reset_flags: got busy=%0b done=%0b err=%0b expected all 0",
               bus.busy, bus.done, bus.err_grant);
    else passCount++;
    checkCount++;
    if (rdyBits() !== 4'b0) $display("[TB] FAIL reset_rdy: got %b expected 0000", rdyBits());
    else passCount++;
    rst = 1'b1;
  endtask

  task automatic test_basic_burst();
    applyStimulus(2, 8'h10, 100, 100, -1, 0);
    checkCount++;
    if (!streamMatches(8'h10))
      $display("[TB] FAIL basic_stream: got %0d beats, expected %0d in-order beats from 0x10", outQ.size(), BL);
    else passCount++;
    checkCount++;
    if (rdyCount !== BL) $display("[TB] FAIL basic_rdy_count: got %0d expected %0d", rdyCount, BL);
    else passCount++;
    checkCount++;
    if (firstRdyCycle !== 1) $display("[TB] FAIL basic_first_rdy: got cycle %0d expected 1", firstRdyCycle);
    else passCount++;
    checkCount++;
    if (lastPushCycle - firstPushCycle !== BL - 1)
      $display("[TB] FAIL basic_throughput: got span %0d expected %0d", lastPushCycle - firstPushCycle, BL - 1);
    else passCount++;
    checkCount++;
    if (doneCount !== 1 || doneCycle !== BL + 1)
      $display("[TB] FAIL basic_done: got count %0d at cycle %0d expected 1 at %0d", doneCount, doneCycle, BL + 1);
    else passCount++;
    @(negedge clk);
    idleInputs();
    #1;
    checkCount++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL basic_idle_after: got busy %0b expected 0", bus.busy);
    else passCount++;
  endtask

  task automatic test_backpressure();
    applyStimulus(2, 8'h10, 100, 100, -1, 3);
    checkCount++;
    if (!streamMatches(8'h10))
      $display("[TB] FAIL bp_stream: got %0d beats, expected %0d in-order beats from 0x10", outQ.size(), BL);
    else passCount++;
    checkCount++;
    if (holdBad !== 0) $display("[TB] FAIL bp_hold: got %0d bad hold cycles expected 0", holdBad);
    else passCount++;
    checkCount++;
    if (doneCount !== 1 || doneCycle !== lastPushCycle)
      $display("[TB] FAIL bp_done: got count %0d at cycle %0d expected 1 at %0d", doneCount, doneCycle, lastPushCycle);
    else passCount++;
  endtask

  task automatic test_illegal_grant();
    @(negedge clk);
    idleInputs();
    bus.ack0 = 1'b1; bus.ack3 = 1'b1;
    bus.vld0 = 1'b1; bus.vld3 = 1'b1;
    #1;
    checkCount++;
    if (bus.err_grant !== 1'b1) $display("[TB] FAIL illegal_err: got %0b expected 1", bus.err_grant);
    else passCount++;
    @(negedge clk);
    bus.ack0 = 1'b0; bus.ack3 = 1'b0;
    #1;
    checkCount++;
    if (bus.err_grant !== 1'b0 || bus.busy !== 1'b0 || rdyBits() !== 4'b0)
      $display("[TB] FAIL illegal_after: got err=%0b busy=%0b rdy=%b expected 0 0 0000",
               bus.err_grant, bus.busy, rdyBits());
    else passCount++;
  endtask

  task automatic test_grant_drop();
    applyStimulus(1, 8'h20, 100, 100, 1, 0);
    checkCount++;
    if (!streamMatches(8'h20))
      $display("[TB] FAIL drop_stream: got %0d beats, expected %0d in-order beats from 0x20", outQ.size(), BL);
    else passCount++;
    checkCount++;
    if (doneCount !== 1) $display("[TB] FAIL drop_done: got %0d expected 1", doneCount);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    int sawDone;
    sawDone = 0;
    @(negedge clk);
    idleInputs();
    drivePort(3, 1'b1, 1'b0, 8'h30);
    @(negedge clk);
    drivePort(3, 1'b1, 1'b1, 8'h30);
    #1;
    if (bus.done) sawDone++;
    @(negedge clk);
    drivePort(3, 1'b1, 1'b1, 8'h31);
    rst = 1'b0;
    #1;
    if (bus.done) sawDone++;
    @(negedge clk);
    idleInputs();
    rst = 1'b1;
    #1;
    checkCount++;
    if (bus.out_vld !== 1'b0 || bus.out_data !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || sawDone !== 0)
      $display("[TB] FAIL midreset_outputs: got vld=%0b data=0x%0h busy=%0b done=%0b sawDone=%0d expected all 0",
               bus.out_vld, bus.out_data, bus.busy, bus.done, sawDone);
    else passCount++;
    applyStimulus(3, 8'h40, 100, 100, -1, 0);
    checkCount++;
    if (!streamMatches(8'h40) || doneCount !== 1)
      $display("[TB] FAIL midreset_fresh: got %0d beats done=%0d expected %0d beats done=1", outQ.size(), doneCount, BL);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 8'h50, 100, 100, -1, 0);
    applyStimulus(3, 8'h60, 100, 100, -1, 0);
    checkCount++;
    if (firstRdyCycle !== 1 || !streamMatches(8'h60))
      $display("[TB] FAIL b2b_second: got first rdy %0d, %0d beats expected 1, %0d", firstRdyCycle, outQ.size(), BL);
    else passCount++;
  endtask

  task automatic test_random();
    int p, vp, rp, dr;
    logic [DW-1:0] base;
    for (int n = 0; n < 20; n++) begin
      p    = int'($urandom_range(3));
      vp   = int'($urandom_range(100, 40));
      rp   = int'($urandom_range(100, 40));
      dr   = int'($urandom_range(BL)) - 1;
      base = DW'($urandom);
      applyStimulus(p, base, vp, rp, dr, 0);
      checkCount++;
      if (!streamMatches(base))
        $display("[TB] FAIL rand_stream[%0d]: got %0d beats, expected %0d in-order beats from 0x%0h", n, outQ.size(), BL, base);
      else passCount++;
      checkCount++;
      if (rdyCount !== BL || wrongRdy !== 0)
        $display("[TB] FAIL rand_rdy[%0d]: got rdy=%0d stray=%0d expected %0d and 0", n, rdyCount, wrongRdy, BL);
      else passCount++;
      checkCount++;
      if (doneCount !== 1 || doneCycle !== lastPushCycle)
        $display("[TB] FAIL rand_done[%0d]: got count %0d at %0d expected 1 at %0d", n, doneCount, doneCycle, lastPushCycle);
      else passCount++;
    end
  endtask

`ifdef GRANT_MUX_TIMEOUT_EN
  task automatic test_timeout();
    int toCycle, doneAt, cyc;
    toCycle = -1; doneAt = -1; cyc = 0;
    @(negedge clk);
    idleInputs();
    drivePort(0, 1'b1, 1'b0, 8'h70);
    @(negedge clk);
    cyc = 1;
    drivePort(0, 1'b1, 1'b1, 8'h70);
    for (int b = 0; b < 60; b++) begin
      if (b > 0) begin
        @(negedge clk);
        cyc++;
        drivePort(0, 1'b1, 1'b0, 8'h71);
      end
      #1;
      if (bus.timeout && toCycle < 0) toCycle = cyc;
      if (bus.done && doneAt < 0) doneAt = cyc;
      if (toCycle >= 0) break;
    end
    checkCount++;
    if (toCycle !== 1 + TO || doneAt !== toCycle)
      $display("[TB] FAIL timeout_pulse: got timeout at %0d done at %0d expected both at %0d", toCycle, doneAt, 1 + TO);
    else passCount++;
    @(negedge clk);
    idleInputs();
    #1;
    checkCount++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL timeout_idle: got busy %0b expected 0", bus.busy);
    else passCount++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_illegal_grant();
    test_grant_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef GRANT_MUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
